// File: rtl/adder_slice_seq.sv
// Sequential driver/collector for an external 3-bit adder slice.
// Walks the operands LSB slice first, chaining the slice carry between cycles.
module adder_slice_seq #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [2:0]       slice_a,
   output logic [2:0]       slice_b,
   output logic             slice_cin,
   input  logic [2:0]       slice_sum,
   input  logic             slice_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int NSLICE = WIDTH / 3;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_width_chk
      $error("adder_slice_seq: WIDTH must be a multiple of 3 and >= 3");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic             r_cout;
   logic             r_out_valid;

   logic [2:0] w_a_sl [NSLICE];
   logic [2:0] w_b_sl [NSLICE];
   logic       w_run;

   for (genvar g = 0; g < NSLICE; g++) begin : g_sl
      assign w_a_sl[g] = r_a[3*g +: 3];
      assign w_b_sl[g] = r_b[3*g +: 3];
   end

   assign w_run     = (r_state == RUN);
   assign slice_a   = w_run ? w_a_sl[r_idx] : 3'd0;
   assign slice_b   = w_run ? w_b_sl[r_idx] : 3'd0;
   assign slice_cin = w_run ? r_carry : 1'b0;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;

   // Carry comes straight from the external slice so approximate slices
   // propagate their errors exactly as a real ripple chain would.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_carry <= in_cin;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               for (int k = 0; k < NSLICE; k++) begin
                  if (r_idx == IW'(k)) r_sum[3*k +: 3] <= slice_sum;
               end
               r_carry <= slice_cout;
               if (r_idx == LAST) begin
                  r_cout      <= slice_cout;
                  r_idx       <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_slice_seq.sv
// Bench for adder_slice_seq with an exact / carry-dropping slice model.
// Directed steps plus a back-to-back random run checked through a scoreboard.
module tb_adder_slice_seq;

   localparam int WIDTH  = 12;
   localparam int NSLICE = WIDTH / 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic [2:0]       slice_a;
   logic [2:0]       slice_b;
   logic             slice_cin;
   logic [2:0]       slice_sum;
   logic             slice_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             approx;
   logic [3:0]       w_s;

   int n_checks = 0;
   int n_err    = 0;
   logic [WIDTH:0] sb [$];

   always #5 clk = ~clk;

   adder_slice_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_cin     (in_cin),
      .slice_a    (slice_a),
      .slice_b    (slice_b),
      .slice_cin  (slice_cin),
      .slice_sum  (slice_sum),
      .slice_cout (slice_cout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_cout   (out_cout)
   );

   // External slice: exact adder, or a stub that always drops the carry.
   always_comb begin
      w_s        = {1'b0, slice_a} + {1'b0, slice_b} + {3'b0, slice_cin};
      slice_sum  = w_s[2:0];
      slice_cout = approx ? 1'b0 : w_s[3];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [WIDTH:0] e;
      chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_sum"}, 32'(out_sum), 32'(e[WIDTH-1:0]));
         chk({tag, "_cout"}, 32'(out_cout), 32'(e[WIDTH]));
      end
   endtask

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH:0] exp,
                        input int hold, input string tag);
      logic       c;
      logic [3:0] s;
      logic [WIDTH:0] held;
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      in_a      = a;
      in_b      = b;
      in_cin    = cin;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 12'($urandom);
      in_b     = 12'($urandom);
      in_cin   = ~cin;
      sb.push_back(exp);
      c = cin;
      for (int k = 0; k < NSLICE; k++) begin
         chk({tag, "_sa"}, 32'(slice_a), 32'(a[3*k +: 3]));
         chk({tag, "_sb"}, 32'(slice_b), 32'(b[3*k +: 3]));
         chk({tag, "_scin"}, 32'(slice_cin), 32'(c));
         chk({tag, "_busy_ov"}, 32'(out_valid), 32'd0);
         chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
         s = {1'b0, a[3*k +: 3]} + {1'b0, b[3*k +: 3]} + {3'b0, c};
         c = approx ? 1'b0 : s[3];
         @(negedge clk);
      end
      chk({tag, "_lat"}, 32'(out_valid), 32'd1);
      chk({tag, "_done_sa"}, 32'(slice_a), 32'd0);
      if (hold > 0) begin
         held = {out_cout, out_sum};
         repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'({out_cout, out_sum}), 32'(held));
            chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      pop_chk(tag);
      @(negedge clk);
      chk({tag, "_rdy_next"}, 32'(in_ready), 32'd1);
      chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int cyc, last, acc, rcv;
      bit new_ops;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      approx    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_rdy", 32'(in_ready), 32'd1);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_cout", 32'(out_cout), 32'd0);
      chk("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);

      do_op(12'hFFF, 12'h001, 1'b0, 13'h1000, 0, "t1");
      do_op(12'h5A3, 12'h25C, 1'b1, 13'h0800, 0, "t2");
      do_op(12'h3C7, 12'h2A9, 1'b0, 13'h0670, 10, "t3");

      // Reset on the edge after the second slice capture.
      @(negedge clk);
      in_a     = 12'hABC;
      in_b     = 12'h777;
      in_cin   = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_rdy", 32'(in_ready), 32'd1);
      chk("t4_ov", 32'(out_valid), 32'd0);
      chk("t4_sum", 32'(out_sum), 32'd0);
      chk("t4_cout", 32'(out_cout), 32'd0);
      chk("t4_scin", 32'(slice_cin), 32'd0);
      do_op(12'h123, 12'h456, 1'b0, 13'h0579, 0, "t4b");

      approx = 1'b1;
      do_op(12'h007, 12'h001, 1'b0, 13'h0000, 0, "t5");
      approx = 1'b0;

      out_ready = 1'b1;
      in_a      = 12'($urandom);
      in_b      = 12'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      cyc = 0; last = 0; acc = 0; rcv = 0; new_ops = 1'b0;
      while (rcv < 50 && cyc < 400) begin
         if (out_valid) begin
            pop_chk("b2b");
            rcv++;
         end
         if (in_ready && in_valid) begin
            sb.push_back({1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin});
            if (acc > 0) chk("b2b_ii", 32'(cyc - last), 32'(NSLICE + 2));
            last = cyc;
            acc++;
            new_ops = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (new_ops) begin
            new_ops = 1'b0;
            if (acc == 50) begin
               in_valid = 1'b0;
            end else begin
               in_a   = 12'($urandom);
               in_b   = 12'($urandom);
               in_cin = 1'($urandom_range(0, 1));
            end
         end
      end
      chk("b2b_rcv", 32'(rcv), 32'd50);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
